// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   - default reset PC and bubble instruction
//   - fetch FSM state encoding (2 bits)
//   - instruction word width and small address helpers
package instr_fetch_unit_pkg;

    localparam int          INSTR_W           = 32;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        FETCH  = 2'd0,  // Req high (or about to be), waiting for ack
        FROZEN = 2'd1,  // decode stalled, no new request issued
        SQUASH = 2'd2   // Req high for a stale address, ack will be dropped
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Unsigned 32-bit increment; wraps from 32'hFFFF_FFFC to 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_skid_buffer.sv
// One-entry {instruction, pc} holding register used when a fetch completes
// while decode is frozen.
// Ports:
//   CLK, RESET           clock, synchronous active-high reset (clears valid only)
//   load, drain, clear   capture new entry / hand entry out / discard entry
//   load_data, load_pc   entry captured on load
//   data, pc, valid      current entry
module fetch_skid_buffer
    import instr_fetch_unit_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [31:0]        load_pc,
    output logic [INSTR_W-1:0] data,
    output logic [31:0]        pc,
    output logic               valid
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Payload needs no reset; it is qualified by valid.
    always_ff @(posedge CLK) begin
        if (load && !clear) begin
            data <= load_data;
            pc   <= load_pc;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage. Holds the fetch address, runs the imem req/ack
// handshake and registers {Instr, PC, PC+4, Valid} toward decode each cycle.
// Ports:
//   CLK, RESET                       clock, synchronous active-high reset
//   Alt_PC_IN, Request_Alt_PC_IN     redirect target / redirect valid
//   WANT_FREEZE_IN                   decode stall request
//   Imem_Req_OUT, Imem_Addr_OUT      read request and word address
//   Imem_Ack_IN, Imem_Data_IN        read completion and instruction word
//   Instr1_OUT, Instr_PC_OUT,
//   Instr_PC_Plus4_OUT, Instr_Valid_OUT  decode-facing output register
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
)(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        Alt_PC_IN,
    input  logic               Request_Alt_PC_IN,
    input  logic               WANT_FREEZE_IN,
    output logic               Imem_Req_OUT,
    output logic [31:0]        Imem_Addr_OUT,
    input  logic               Imem_Ack_IN,
    input  logic [INSTR_W-1:0] Imem_Data_IN,
    output logic [INSTR_W-1:0] Instr1_OUT,
    output logic [31:0]        Instr_PC_OUT,
    output logic [31:0]        Instr_PC_Plus4_OUT,
    output logic               Instr_Valid_OUT
);

    fetch_state_t       state;
    logic               pend_vld;   // redirect received while frozen
    logic [31:0]        pend_tgt;   // target for SQUASH or deferred redirect
    logic               ack_v;
    logic               redir;
    logic               freeze;
    logic [31:0]        tgt;
    logic               skid_load;
    logic               skid_drain;
    logic               skid_clear;
    logic [INSTR_W-1:0] skid_data;
    logic [31:0]        skid_pc;
    logic               skid_vld;

    assign ack_v  = Imem_Req_OUT & Imem_Ack_IN;
    assign redir  = Request_Alt_PC_IN;
    assign freeze = WANT_FREEZE_IN;
    assign tgt    = word_align(Alt_PC_IN);

    fetch_skid_buffer u_skid (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (skid_clear),
        .load_data (Imem_Data_IN),
        .load_pc   (Imem_Addr_OUT),
        .data      (skid_data),
        .pc        (skid_pc),
        .valid     (skid_vld)
    );

    // Skid control mirrors the FSM decisions below.
    always_comb begin
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        case (state)
            FETCH: begin
                if (redir)                skid_clear = 1'b1;
                else if (freeze && ack_v) skid_load  = 1'b1;
            end
            FROZEN: begin
                if (redir)                     skid_clear = 1'b1;
                else if (freeze)               skid_load  = ack_v && !pend_vld;
                else if (pend_vld)             skid_clear = 1'b1;
                else if (skid_vld)             skid_drain = 1'b1;
            end
            default: skid_clear = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state              <= FETCH;
            pend_vld           <= 1'b0;
            Imem_Req_OUT       <= 1'b0;
            Imem_Addr_OUT      <= RESET_PC;
            Instr1_OUT         <= NOP_INSTR;
            Instr_PC_OUT       <= 32'd0;
            Instr_PC_Plus4_OUT <= 32'd0;
            Instr_Valid_OUT    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redir && !freeze) begin
                        Instr1_OUT      <= NOP_INSTR;
                        Instr_Valid_OUT <= 1'b0;
                        // Address must stay put until the in-flight read acks.
                        if (Imem_Req_OUT && !Imem_Ack_IN) begin
                            state    <= SQUASH;
                            pend_tgt <= tgt;
                        end else begin
                            Imem_Addr_OUT <= tgt;
                            Imem_Req_OUT  <= 1'b1;
                        end
                    end else if (freeze) begin
                        state <= FROZEN;
                        if (redir) begin
                            pend_vld <= 1'b1;
                            pend_tgt <= tgt;
                        end
                        if (ack_v) begin
                            Imem_Req_OUT <= 1'b0;
                            if (!redir) Imem_Addr_OUT <= pc_plus4(Imem_Addr_OUT);
                        end
                    end else if (ack_v) begin
                        Instr1_OUT         <= Imem_Data_IN;
                        Instr_PC_OUT       <= Imem_Addr_OUT;
                        Instr_PC_Plus4_OUT <= pc_plus4(Imem_Addr_OUT);
                        Instr_Valid_OUT    <= 1'b1;
                        Imem_Addr_OUT      <= pc_plus4(Imem_Addr_OUT);
                    end else begin
                        Instr1_OUT      <= NOP_INSTR;
                        Instr_Valid_OUT <= 1'b0;
                        Imem_Req_OUT    <= 1'b1;
                    end
                end
                FROZEN: begin
                    if (redir) begin
                        pend_vld <= 1'b1;
                        pend_tgt <= tgt;
                    end
                    if (freeze) begin
                        // A read still in flight completes; its data is kept
                        // unless a redirect has made it stale.
                        if (ack_v) begin
                            Imem_Req_OUT <= 1'b0;
                            if (!(pend_vld || redir)) Imem_Addr_OUT <= pc_plus4(Imem_Addr_OUT);
                        end
                    end else if (pend_vld || redir) begin
                        Instr1_OUT      <= NOP_INSTR;
                        Instr_Valid_OUT <= 1'b0;
                        pend_vld        <= 1'b0;
                        if (Imem_Req_OUT && !Imem_Ack_IN) begin
                            state    <= SQUASH;
                            pend_tgt <= redir ? tgt : pend_tgt;
                        end else begin
                            state         <= FETCH;
                            Imem_Addr_OUT <= redir ? tgt : pend_tgt;
                            Imem_Req_OUT  <= 1'b1;
                        end
                    end else if (skid_vld) begin
                        // Address was already advanced past the skid entry.
                        state              <= FETCH;
                        Instr1_OUT         <= skid_data;
                        Instr_PC_OUT       <= skid_pc;
                        Instr_PC_Plus4_OUT <= pc_plus4(skid_pc);
                        Instr_Valid_OUT    <= 1'b1;
                        Imem_Req_OUT       <= 1'b1;
                    end else begin
                        state        <= FETCH;
                        Imem_Req_OUT <= 1'b1;
                        if (ack_v) begin
                            Instr1_OUT         <= Imem_Data_IN;
                            Instr_PC_OUT       <= Imem_Addr_OUT;
                            Instr_PC_Plus4_OUT <= pc_plus4(Imem_Addr_OUT);
                            Instr_Valid_OUT    <= 1'b1;
                            Imem_Addr_OUT      <= pc_plus4(Imem_Addr_OUT);
                        end else begin
                            Instr1_OUT      <= NOP_INSTR;
                            Instr_Valid_OUT <= 1'b0;
                        end
                    end
                end
                SQUASH: begin
                    if (!freeze) begin
                        Instr1_OUT      <= NOP_INSTR;
                        Instr_Valid_OUT <= 1'b0;
                    end
                    if (redir) pend_tgt <= tgt;
                    // The stale read's data is dropped; only its ack matters.
                    if (ack_v) begin
                        if (freeze) begin
                            state        <= FROZEN;
                            pend_vld     <= 1'b1;
                            Imem_Req_OUT <= 1'b0;
                        end else begin
                            state         <= FETCH;
                            Imem_Addr_OUT <= redir ? tgt : pend_tgt;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Memory returns word index
// (addr - 0x400000) >> 2 whenever the bench raises ack.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] Alt_PC_IN;
    logic        Request_Alt_PC_IN;
    logic        WANT_FREEZE_IN;
    logic        Imem_Req_OUT;
    logic [31:0] Imem_Addr_OUT;
    logic        Imem_Ack_IN;
    logic [31:0] Imem_Data_IN;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic        Instr_Valid_OUT;

    int tests_run    = 0;
    int tests_failed = 0;

    instr_fetch_unit dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Alt_PC_IN          (Alt_PC_IN),
        .Request_Alt_PC_IN  (Request_Alt_PC_IN),
        .WANT_FREEZE_IN     (WANT_FREEZE_IN),
        .Imem_Req_OUT       (Imem_Req_OUT),
        .Imem_Addr_OUT      (Imem_Addr_OUT),
        .Imem_Ack_IN        (Imem_Ack_IN),
        .Imem_Data_IN       (Imem_Data_IN),
        .Instr1_OUT         (Instr1_OUT),
        .Instr_PC_OUT       (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT),
        .Instr_Valid_OUT    (Instr_Valid_OUT)
    );

    assign Imem_Data_IN = (Imem_Addr_OUT - 32'h0040_0000) >> 2;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Checks the full decode-facing register.
    task automatic check_out(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic valid);
        check_eq({tag, ".instr"}, Instr1_OUT, instr);
        check_eq({tag, ".pc"}, Instr_PC_OUT, pc);
        check_eq({tag, ".pc4"}, Instr_PC_Plus4_OUT, pc + 32'd4);
        check_eq({tag, ".valid"}, {31'd0, Instr_Valid_OUT}, {31'd0, valid});
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check_eq({tag, ".req"}, {31'd0, Imem_Req_OUT}, {31'd0, req});
        check_eq({tag, ".addr"}, Imem_Addr_OUT, addr);
    endtask

    initial begin
        RESET = 1'b1; Alt_PC_IN = 32'd0; Request_Alt_PC_IN = 1'b0;
        WANT_FREEZE_IN = 1'b0; Imem_Ack_IN = 1'b1;

        // 1: reset, then ack every cycle
        tick();
        check_req("rst", 1'b0, 32'h0040_0000);
        check_eq("rst.instr", Instr1_OUT, 32'd0);
        check_eq("rst.pc", Instr_PC_OUT, 32'd0);
        check_eq("rst.pc4", Instr_PC_Plus4_OUT, 32'd0);
        check_eq("rst.valid", {31'd0, Instr_Valid_OUT}, 32'd0);
        RESET = 1'b0;
        tick();
        check_req("t1.e1", 1'b1, 32'h0040_0000);
        check_eq("t1.e1.valid", {31'd0, Instr_Valid_OUT}, 32'd0);
        tick();
        check_out("t1.e2", 32'd0, 32'h0040_0000, 1'b1);
        check_req("t1.e2", 1'b1, 32'h0040_0004);
        tick();
        check_out("t1.e3", 32'd1, 32'h0040_0004, 1'b1);
        check_req("t1.e3", 1'b1, 32'h0040_0008);

        // 2: ack withheld 3 cycles at 0x400008
        Imem_Ack_IN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t2.bub.instr", Instr1_OUT, 32'd0);
            check_eq("t2.bub.valid", {31'd0, Instr_Valid_OUT}, 32'd0);
            check_req("t2.bub", 1'b1, 32'h0040_0008);
        end
        Imem_Ack_IN = 1'b1;
        tick();
        check_out("t2.dlv", 32'd2, 32'h0040_0008, 1'b1);
        check_req("t2.dlv", 1'b1, 32'h0040_000C);

        // 3: freeze 4 cycles, ack lands in freeze cycle 1
        WANT_FREEZE_IN = 1'b1;
        tick();
        Imem_Ack_IN = 1'b0;
        check_out("t3.f1", 32'd2, 32'h0040_0008, 1'b1);
        check_eq("t3.f1.req", {31'd0, Imem_Req_OUT}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("t3.fz", 32'd2, 32'h0040_0008, 1'b1);
            check_eq("t3.fz.req", {31'd0, Imem_Req_OUT}, 32'd0);
        end
        WANT_FREEZE_IN = 1'b0;
        tick();
        check_out("t3.rel", 32'd3, 32'h0040_000C, 1'b1);
        check_req("t3.rel", 1'b1, 32'h0040_0010);
        Imem_Ack_IN = 1'b1;
        tick();
        check_out("t3.next", 32'd4, 32'h0040_0010, 1'b1);

        // 4: redirect with request pending and no ack
        Imem_Ack_IN = 1'b0; Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h0040_0100;
        tick();
        check_req("t4.sq", 1'b1, 32'h0040_0014);
        check_eq("t4.sq.valid", {31'd0, Instr_Valid_OUT}, 32'd0);
        Request_Alt_PC_IN = 1'b0; Imem_Ack_IN = 1'b1;
        tick();
        check_eq("t4.stale.valid", {31'd0, Instr_Valid_OUT}, 32'd0);
        check_req("t4.tgt", 1'b1, 32'h0040_0100);
        tick();
        check_out("t4.dlv", 32'h40, 32'h0040_0100, 1'b1);

        // 5: redirect coincident with ack, unaligned target
        Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h0040_0103;
        tick();
        check_eq("t5.drop.valid", {31'd0, Instr_Valid_OUT}, 32'd0);
        check_req("t5.tgt", 1'b1, 32'h0040_0100);
        Request_Alt_PC_IN = 1'b0;
        tick();
        check_out("t5.dlv", 32'h40, 32'h0040_0100, 1'b1);

        // PC+4 wrap at top of address space
        Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'hFFFF_FFFC;
        tick();
        Request_Alt_PC_IN = 1'b0;
        check_req("wrap.tgt", 1'b1, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap.instr", Instr1_OUT, 32'h3FEF_FFFF);
        check_eq("wrap.pc", Instr_PC_OUT, 32'hFFFF_FFFC);
        check_eq("wrap.pc4", Instr_PC_Plus4_OUT, 32'd0);
        check_req("wrap.next", 1'b1, 32'd0);

        // Redirect while frozen is deferred until release; acked data is dropped
        WANT_FREEZE_IN = 1'b1; Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h0040_0200;
        tick();
        Request_Alt_PC_IN = 1'b0; Imem_Ack_IN = 1'b0;
        check_eq("frz.rd.instr", Instr1_OUT, 32'h3FEF_FFFF);
        check_eq("frz.rd.req", {31'd0, Imem_Req_OUT}, 32'd0);
        tick();
        WANT_FREEZE_IN = 1'b0;
        tick();
        check_req("frz.rd.tgt", 1'b1, 32'h0040_0200);
        check_eq("frz.rd.valid", {31'd0, Instr_Valid_OUT}, 32'd0);
        Imem_Ack_IN = 1'b1;
        tick();
        check_out("frz.rd.dlv", 32'h80, 32'h0040_0200, 1'b1);

        // 6: reset while a request is pending, ack arrives next cycle
        Imem_Ack_IN = 1'b0; RESET = 1'b1;
        tick();
        check_req("t6.rst", 1'b0, 32'h0040_0000);
        check_eq("t6.rst.valid", {31'd0, Instr_Valid_OUT}, 32'd0);
        RESET = 1'b0; Imem_Ack_IN = 1'b1;
        tick();
        check_eq("t6.ign.valid", {31'd0, Instr_Valid_OUT}, 32'd0);
        check_eq("t6.ign.pc", Instr_PC_OUT, 32'd0);
        check_req("t6.ign", 1'b1, 32'h0040_0000);
        tick();
        check_out("t6.refetch", 32'd0, 32'h0040_0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
